timer_digit_display: RTL

Display-side consumer of the game-clock digit bus. It snapshots the three BCD timer digits (minutes, seconds-tens, seconds-units) and the game-over flag, and time-multiplexes them onto a common-anode 3-digit seven-segment display. It blinks the colon on `one_sec` and flashes the whole display once the game is over. It sits between the game timer and the board's seven-segment pins.

---
 rtl/timer_display_pkg.sv | 45 ++++
 rtl/bcd_to_7seg.sv | 17 +
 rtl/timer_digit_display.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/timer_display_pkg.sv
// Shared constants and types for the game-clock seven-segment display.
// Glyphs are active-high here; the top inverts them in its output register.
package timer_display_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] MAX_DIGIT = 4'd9;
    localparam logic [3:0] MAX_TENS  = 4'd5;

    typedef enum logic [1:0] {
        SLOT_UNITS = 2'd0,
        SLOT_TENS  = 2'd1,
        SLOT_MIN   = 2'd2
    } slot_t;

    function automatic logic [6:0] seg_glyph(input logic [3:0] value);
        logic [6:0] g;
        case (value)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_DASH;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-high seven-segment glyph, with a per-position
// upper limit; any value above the limit decodes to a dash and flags invalid.
module bcd_to_7seg
    import timer_display_pkg::*;
(
    input  logic [3:0] value_i,
    input  logic [3:0] max_digit_i,
    output logic [6:0] glyph_o,
    output logic       invalid_o
);

    always_comb begin
        invalid_o = (value_i > max_digit_i) || (value_i > MAX_DIGIT);
        glyph_o   = invalid_o ? SEG_DASH : seg_glyph(value_i);
    end

endmodule

// File: rtl/timer_digit_display.sv
// Snapshots the three timer digits once per frame and scans them onto a
// common-anode 3-digit display with a blinking colon and game-over flash.
module timer_digit_display
    import timer_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_sec,
    input  logic [3:0] firstSecondsDig,
    input  logic [3:0] secondSecondsDig,
    input  logic [3:0] minutesDig,
    input  logic       game_over,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [2:0] an_n,
    output logic       digit_err
);

    localparam int unsigned   CntW     = $clog2(SCAN_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntBlk = CntW'(BLANK_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;
    slot_t           slot_q, slot_d;
    logic [3:0]      units_q, units_d, tens_q, tens_d, min_q, min_d;
    logic            colon_on_q, colon_on_d;
    logic            flash_q, flash_d;
    logic            game_over_q, game_over_d;
    logic [6:0]      seg_n_q, seg_n_d;
    logic            dp_n_q, dp_n_d;
    logic [2:0]      an_n_q, an_n_d;
    logic            digit_err_q, digit_err_d;

    logic [3:0]      cur_digit, cur_max;
    logic [6:0]      glyph;
    logic            invalid;
    logic            snapshot, go_rise, blank, lit;

    bcd_to_7seg u_dec (
        .value_i     (cur_digit),
        .max_digit_i (cur_max),
        .glyph_o     (glyph),
        .invalid_o   (invalid)
    );

    always_comb begin
        cnt_d  = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        slot_d = slot_q;
        if (cnt_q == CntMax) begin
            unique case (slot_q)
                SLOT_UNITS: slot_d = SLOT_TENS;
                SLOT_TENS:  slot_d = SLOT_MIN;
                default:    slot_d = SLOT_UNITS;
            endcase
        end

        // All three digits load together so a frame never mixes two times.
        snapshot = (slot_q == SLOT_UNITS) && (cnt_q == '0);
        units_d  = snapshot ? firstSecondsDig  : units_q;
        tens_d   = snapshot ? secondSecondsDig : tens_q;
        min_d    = snapshot ? minutesDig       : min_q;

        game_over_d = game_over;
        go_rise     = game_over && !game_over_q;
        colon_on_d  = game_over ? 1'b1 : (colon_on_q ^ one_sec);
        if (go_rise) begin
            flash_d = 1'b1;
        end else if (game_over && one_sec) begin
            flash_d = ~flash_q;
        end else begin
            flash_d = flash_q;
        end

        cur_digit = units_q;
        cur_max   = MAX_DIGIT;
        unique case (slot_q)
            SLOT_TENS: begin
                cur_digit = tens_q;
                cur_max   = MAX_TENS;
            end
            SLOT_MIN:  cur_digit = min_q;
            default:   cur_digit = units_q;
        endcase

        // game_over_q gating keeps a stale flash=0 from hiding the rising-edge cycle.
        blank = game_over && game_over_q && !flash_q;
        lit   = (cnt_q >= CntBlk) && !blank;

        an_n_d = 3'b111;
        if (lit) begin
            unique case (slot_q)
                SLOT_TENS: an_n_d = 3'b101;
                SLOT_MIN:  an_n_d = 3'b011;
                default:   an_n_d = 3'b110;
            endcase
        end
        dp_n_d      = !((slot_q == SLOT_MIN) && colon_on_q && !blank);
        seg_n_d     = ~glyph;
        digit_err_d = digit_err_q || invalid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            slot_q      <= SLOT_UNITS;
            units_q     <= 4'd0;
            tens_q      <= 4'd0;
            min_q       <= 4'd0;
            colon_on_q  <= 1'b1;
            flash_q     <= 1'b1;
            game_over_q <= 1'b0;
            seg_n_q     <= 7'h7F;
            dp_n_q      <= 1'b1;
            an_n_q      <= 3'b111;
            digit_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            units_q     <= units_d;
            tens_q      <= tens_d;
            min_q       <= min_d;
            colon_on_q  <= colon_on_d;
            flash_q     <= flash_d;
            game_over_q <= game_over_d;
            seg_n_q     <= seg_n_d;
            dp_n_q      <= dp_n_d;
            an_n_q      <= an_n_d;
            digit_err_q <= digit_err_d;
        end
    end

    assign seg_n     = seg_n_q;
    assign dp_n      = dp_n_q;
    assign an_n      = an_n_q;
    assign digit_err = digit_err_q;

endmodule
